// File: rtl/seq_addsub_unit.sv
// Multi-cycle add/subtract unit: processes CHUNK bits per clock, LSB first,
// with a start/busy/done handshake and carry, signed-overflow and zero flags.
module seq_addsub_unit #(
    parameter int WIDTH = 10,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    generate
        if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
            $error("seq_addsub_unit: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] partial_next;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [CHUNK:0]   chunk_sum;
    logic             ready;
    logic             accept;
    logic             last_chunk;
    logic             ovf_next;

    assign ready      = (state == IDLE) || (state == DONE);
    assign accept     = ready && start;
    assign last_chunk = (cnt == LAST);
    assign busy       = (state == RUN);
    assign done       = (state == DONE);

    // One chunk of the ripple: the carry register links successive chunks.
    always_comb begin
        // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
        chunk_sum    = {1'b0, a_reg[cnt*CHUNK +: CHUNK]}
                     + {1'b0, b_reg[cnt*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, carry};
        partial_next = partial;
        partial_next[cnt*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        ovf_next     = (a_reg[WIDTH-1] == b_reg[WIDTH-1])
                    && (partial_next[WIDTH-1] != a_reg[WIDTH-1]);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: state_next = start ? RUN : IDLE;
            RUN:        if (last_chunk) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: operand and partial registers are cleared too, so a reset mid-RUN leaves no stale data.
            a_reg     <= '0;
            b_reg     <= '0;
            partial   <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else if (accept) begin
            // Subtraction is A + ~B + 1: invert B here and seed the carry with op_sub.
            a_reg   <= a;
            b_reg   <= b ^ {WIDTH{op_sub}};
            carry   <= op_sub;
            cnt     <= '0;
            partial <= '0;
        end else if (state == RUN) begin
            partial <= partial_next;
            carry   <= chunk_sum[CHUNK];
            cnt     <= cnt + 1'b1;
            if (last_chunk) begin
                result    <= partial_next;
                carry_out <= chunk_sum[CHUNK];
                overflow  <= ovf_next;
                zero      <= (partial_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_seq_addsub_unit.sv
// Scoreboard bench for seq_addsub_unit: three configurations (10/2, 16/4, 8/8)
// driven by directed and random ops, checked against an arithmetic model.
module tb_seq_addsub_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic       start0, op0, busy0, done0, c0, v0, z0;
    logic [9:0] a0, b0, res0;
    logic        start1, op1, busy1, done1, c1, v1, z1;
    logic [15:0] a1, b1, res1;
    logic       start2, op2, busy2, done2, c2, v2, z2;
    logic [7:0] a2, b2, res2;

    seq_addsub_unit #(.WIDTH(10), .CHUNK(2)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .op_sub(op0), .a(a0), .b(b0),
        .busy(busy0), .done(done0), .result(res0), .carry_out(c0), .overflow(v0), .zero(z0));
    seq_addsub_unit #(.WIDTH(16), .CHUNK(4)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .op_sub(op1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .result(res1), .carry_out(c1), .overflow(v1), .zero(z1));
    seq_addsub_unit #(.WIDTH(8), .CHUNK(8)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .op_sub(op2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .result(res2), .carry_out(c2), .overflow(v2), .zero(z2));

    typedef struct {
        logic [15:0] res;
        logic        c;
        logic        v;
        logic        z;
        int          tag;
    } exp_t;

    typedef struct {
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        c;
        logic        v;
        logic        z;
    } vec_t;

    localparam int WID [3] = '{10, 16, 8};
    localparam int NCH [3] = '{5, 4, 1};

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    function automatic exp_t model(input int w, input logic op, input logic [15:0] a, input logic [15:0] b);
        exp_t   e;
        longint full = longint'(1) << w;
        longint ua   = longint'(a);
        longint ub   = longint'(b);
        longint sa   = (ua >= full / 2) ? ua - full : ua;
        longint sb   = (ub >= full / 2) ? ub - full : ub;
        longint sum  = op ? ua - ub : ua + ub;
        longint ssum = op ? sa - sb : sa + sb;
        e.res = 16'(((sum % full) + full) % full);
        e.c   = op ? (ua >= ub) : (sum >= full);
        e.v   = (ssum < -(full / 2)) || (ssum >= full / 2);
        e.z   = (e.res == 16'd0);
        e.tag = 0;
        return e;
    endfunction

    task automatic get_outs(input int idx, output logic bsy, output logic dn,
                            output logic [15:0] r, output logic c, output logic v, output logic z);
        case (idx)
            0:       begin bsy = busy0; dn = done0; r = 16'(res0); c = c0; v = v0; z = z0; end
            1:       begin bsy = busy1; dn = done1; r = res1;      c = c1; v = v1; z = z1; end
            default: begin bsy = busy2; dn = done2; r = 16'(res2); c = c2; v = v2; z = z2; end
        endcase
    endtask

    task automatic drive(input int idx, input logic st, input logic op, input logic [15:0] av, input logic [15:0] bv);
        case (idx)
            0:       begin start0 = st; op0 = op; a0 = av[9:0]; b0 = bv[9:0]; end
            1:       begin start1 = st; op1 = op; a1 = av;      b1 = bv;      end
            default: begin start2 = st; op2 = op; a2 = av[7:0]; b2 = bv[7:0]; end
        endcase
    endtask

    function automatic int q_size(input int idx);
        case (idx)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push_exp(input int idx, input exp_t e);
        case (idx)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int idx, output exp_t e);
        case (idx)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    // Monitor: pops and compares on every done pulse, checks hold in between.
    logic [15:0] st_res [3];
    logic        st_c [3];
    logic        st_v [3];
    logic        st_z [3];
    int          bcnt [3];

    task automatic monitor_one(input int i);
        logic bsy, dn, c, v, z;
        logic [15:0] r;
        exp_t e;
        get_outs(i, bsy, dn, r, c, v, z);
        if (bsy) bcnt[i]++;
        if (dn) begin
            check($sformatf("d%0d_done_while_busy", i), 32'(bsy), 32'd0);
            if (q_size(i) == 0) begin
                check($sformatf("d%0d_unexpected_done", i), 32'd1, 32'd0);
            end else begin
                pop_exp(i, e);
                check($sformatf("d%0d_latency", i), 32'(cyc - e.tag), 32'(NCH[i]));
                check($sformatf("d%0d_busy_cycles", i), 32'(bcnt[i]), 32'(NCH[i]));
                check($sformatf("d%0d_result", i), 32'(r), 32'(e.res));
                check($sformatf("d%0d_carry_out", i), 32'(c), 32'(e.c));
                check($sformatf("d%0d_overflow", i), 32'(v), 32'(e.v));
                check($sformatf("d%0d_zero", i), 32'(z), 32'(e.z));
            end
            bcnt[i]   = 0;
            st_res[i] = r;
            st_c[i]   = c;
            st_v[i]   = v;
            st_z[i]   = z;
        end else begin
            check($sformatf("d%0d_hold_outputs", i), {13'd0, r, c, v, z},
                  {13'd0, st_res[i], st_c[i], st_v[i], st_z[i]});
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            q0.delete();
            q1.delete();
            q2.delete();
            for (int i = 0; i < 3; i++) begin
                st_res[i] = '0; st_c[i] = 1'b0; st_v[i] = 1'b0; st_z[i] = 1'b0; bcnt[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) monitor_one(i);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int idx, input logic op, input logic [15:0] av, input logic [15:0] bv, input exp_t e);
        logic bsy, dn, c, v, z;
        logic [15:0] r;
        int n = 0;
        get_outs(idx, bsy, dn, r, c, v, z);
        while (bsy && n < 100) begin
            tick();
            n++;
            get_outs(idx, bsy, dn, r, c, v, z);
        end
        if (bsy) check($sformatf("d%0d_issue_timeout", idx), 32'd1, 32'd0);
        e.tag = cyc + 1;
        push_exp(idx, e);
        drive(idx, 1'b1, op, av, bv);
        tick();
        // Scramble operands while RUN; the unit must ignore them.
        drive(idx, 1'b0, ~op, 16'($urandom), 16'($urandom));
    endtask

    task automatic wait_done(input int idx);
        logic bsy, dn, c, v, z;
        logic [15:0] r;
        int n = 0;
        get_outs(idx, bsy, dn, r, c, v, z);
        while (!dn && n < 100) begin
            tick();
            n++;
            get_outs(idx, bsy, dn, r, c, v, z);
        end
        if (!dn) check($sformatf("d%0d_done_timeout", idx), 32'd1, 32'd0);
    endtask

    task automatic drain(input int idx);
        int n = 0;
        while (q_size(idx) != 0 && n < 100) begin
            tick();
            n++;
        end
        if (q_size(idx) != 0) check($sformatf("d%0d_drain_timeout", idx), 32'(q_size(idx)), 32'd0);
    endtask

    function automatic logic [15:0] rand_val(input int w);
        logic [15:0] mask = 16'((32'd1 << w) - 1);
        logic [15:0] msb  = 16'(32'd1 << (w - 1));
        case ($urandom_range(0, 7))
            0:       return 16'd0;
            1:       return mask;
            2:       return msb;
            3:       return msb - 16'd1;
            default: return 16'($urandom) & mask;
        endcase
    endfunction

    task automatic rand_op(input int idx);
        logic        op = 1'($urandom_range(0, 1));
        logic [15:0] av = rand_val(WID[idx]);
        logic [15:0] bv = rand_val(WID[idx]);
        issue(idx, op, av, bv, model(WID[idx], op, av, bv));
        if ($urandom_range(0, 3) == 0) tick();
    endtask

    function automatic exp_t vec_exp(input vec_t t);
        exp_t e;
        e.res = t.res; e.c = t.c; e.v = t.v; e.z = t.z; e.tag = 0;
        return e;
    endfunction

    task automatic check_all_zero(input int idx, input string tag);
        logic bsy, dn, c, v, z;
        logic [15:0] r;
        get_outs(idx, bsy, dn, r, c, v, z);
        check($sformatf("d%0d_%s_busy", idx, tag), 32'(bsy), 32'd0);
        check($sformatf("d%0d_%s_done", idx, tag), 32'(dn), 32'd0);
        check($sformatf("d%0d_%s_result", idx, tag), 32'(r), 32'd0);
        check($sformatf("d%0d_%s_flags", idx, tag), {29'd0, c, v, z}, 32'd0);
    endtask

    vec_t dir [6];

    initial begin
        dir[0] = '{1'b1, 16'd300, 16'd125, 16'd175,  1'b1, 1'b0, 1'b0};
        dir[1] = '{1'b1, 16'd5,   16'd7,   16'd1022, 1'b0, 1'b0, 1'b0};
        dir[2] = '{1'b0, 16'd1023, 16'd1,  16'd0,    1'b1, 1'b0, 1'b1};
        dir[3] = '{1'b0, 16'd511, 16'd1,   16'd512,  1'b0, 1'b1, 1'b0};
        dir[4] = '{1'b1, 16'd512, 16'd1,   16'd511,  1'b1, 1'b1, 1'b0};
        dir[5] = '{1'b1, 16'd0,   16'd0,   16'd0,    1'b1, 1'b0, 1'b1};

        reset = 1'b1;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 16'd0, 16'd0);
        repeat (3) tick();
        for (int i = 0; i < 3; i++) check_all_zero(i, "reset");
        reset = 1'b0;
        tick();

        // Directed W=10: start during RUN ignored, then back-to-back starts in DONE.
        issue(0, dir[0].op, dir[0].a, dir[0].b, vec_exp(dir[0]));
        tick();
        drive(0, 1'b1, 1'b0, 16'd1, 16'd2);
        tick();
        drive(0, 1'b0, 1'b0, 16'd0, 16'd0);
        for (int k = 1; k < 6; k++) begin
            wait_done(0);
            issue(0, dir[k].op, dir[k].a, dir[k].b, vec_exp(dir[k]));
        end
        drain(0);
        repeat (3) tick();

        // Reset two cycles into RUN: operation discarded, outputs cleared.
        issue(0, 1'b0, 16'd100, 16'd200, model(10, 1'b0, 16'd100, 16'd200));
        tick();
        reset = 1'b1;
        tick();
        check_all_zero(0, "midrun_reset");
        reset = 1'b0;
        repeat (8) tick();
        issue(0, 1'b0, 16'd10, 16'd20, '{16'd30, 1'b0, 1'b0, 1'b0, 0});
        drain(0);

        for (int k = 0; k < 200; k++)  rand_op(0);
        drain(0);
        for (int k = 0; k < 1000; k++) rand_op(1);
        drain(1);
        for (int k = 0; k < 1000; k++) rand_op(2);
        drain(2);
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
